// File: rtl/vram_multibank.sv
// Multi-bank VRAM behind the epochtv1 VDC memory pins: read-latency pipeline, open-bus VDO,
// and a low-priority loader port for preloading and inspecting memory without disturbing the VDC.
module vram_multibank #(
    parameter int NBANK         = 2,
    parameter int AW            = 11,
    parameter int DW            = 8,
    parameter int RD_LAT        = 1,
    parameter int OPEN_BUS_HOLD = 1,
    localparam int BW           = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic             CLK,
    input  logic             RESB,
    input  logic             CE,
    input  logic [AW-1:0]    VA,
    input  logic [DW-1:0]    VDI,
    input  logic [NBANK-1:0] nVCS,
    input  logic             nVWE,
    output logic [DW-1:0]    VDO,
    input  logic             LD_REQ,
    input  logic             LD_WE,
    input  logic [BW-1:0]    LD_BANK,
    input  logic [AW-1:0]    LD_A,
    input  logic [DW-1:0]    LD_DI,
    output logic             LD_ACK,
    output logic [DW-1:0]    LD_DO,
    input  logic             CLR_ERR,
    output logic             MULTI_CS_ERR
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACK  = 1'b1;

    logic [DW-1:0] mem [NBANK][2**AW];
    logic [3:0]    sel_count;
    logic [BW-1:0] sel_bank;
    logic          vdc_cycle;
    logic          single_sel;
    logic          multi_sel;
    logic          vdc_write;
    logic          launch_valid;
    logic [DW-1:0] launch_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [0:0]    state;
    logic          ld_grant;
    logic          ld_bank_ok;

    always_comb begin
        sel_count = '0;
        sel_bank  = '0;
        for (int i = 0; i < NBANK; i++) begin
            if (!nVCS[i]) begin
                sel_count = sel_count + 4'd1;
                sel_bank  = BW'(i);
            end
        end
    end

    assign vdc_cycle  = CE && (sel_count != 4'd0);
    assign single_sel = (sel_count == 4'd1);
    assign multi_sel  = vdc_cycle && !single_sel;
    assign vdc_write  = vdc_cycle && single_sel && !nVWE;

    // A contended select still returns a slot, reading as open bus
    assign launch_valid = vdc_cycle && (multi_sel || nVWE);
    assign launch_data  = multi_sel ? '1 : mem[sel_bank][VA];

    assign ld_bank_ok = ({1'b0, LD_BANK} < (BW+1)'(NBANK));
    assign ld_grant   = (state == ST_IDLE) && LD_REQ && !vdc_cycle;

    always_ff @(posedge CLK) begin
        if (RESB && vdc_write)
            mem[sel_bank][VA] <= VDI;
        else if (RESB && ld_grant && LD_WE && ld_bank_ok)
            mem[LD_BANK][LD_A] <= LD_DI;
    end

    // RD_LAT-1 register stages sit between the memory read and the VDO register
    if (RD_LAT == 1) begin : g_direct
        assign out_valid = launch_valid;
        assign out_data  = launch_data;
    end else begin : g_pipe
        logic [RD_LAT-2:0] stage_valid;
        logic [DW-1:0]     stage_data [RD_LAT-1];

        always_ff @(posedge CLK or negedge RESB) begin
            if (!RESB) begin
                stage_valid <= '0;
            end else begin
                stage_valid[0] <= launch_valid;
                for (int i = 1; i < RD_LAT - 1; i++)
                    stage_valid[i] <= stage_valid[i-1];
            end
        end

        always_ff @(posedge CLK) begin
            stage_data[0] <= launch_data;
            for (int i = 1; i < RD_LAT - 1; i++)
                stage_data[i] <= stage_data[i-1];
        end

        assign out_valid = stage_valid[RD_LAT-2];
        assign out_data  = stage_data[RD_LAT-2];
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB)
            VDO <= '1;
        else if (out_valid)
            VDO <= out_data;
        else if (OPEN_BUS_HOLD == 0)
            VDO <= '1;
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state <= ST_IDLE;
            LD_DO <= '0;
        end else if (ld_grant) begin
            state <= ST_ACK;
            if (!LD_WE)
                LD_DO <= ld_bank_ok ? mem[LD_BANK][LD_A] : '1;
        end else begin
            state <= ST_IDLE;
        end
    end

    assign LD_ACK = (state == ST_ACK);

    // A new multi-select outranks a simultaneous clear
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB)
            MULTI_CS_ERR <= 1'b0;
        else if (multi_sel)
            MULTI_CS_ERR <= 1'b1;
        else if (CLR_ERR)
            MULTI_CS_ERR <= 1'b0;
    end

endmodule

// File: tb/tb_vram_multibank.sv
// Bench for vram_multibank: six instances (RD_LAT 1..4, no-hold open bus, three banks) share one
// stimulus stream and are compared every cycle against a simple memory/history model.
module tb_vram_multibank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic [10:0] va;
    logic [7:0]  vdi;
    logic [1:0]  nvcs;
    logic        nvwe;
    logic        ld_req;
    logic        ld_we;
    logic [1:0]  ld_bank;
    logic [10:0] ld_a;
    logic [7:0]  ld_di;
    logic        clr_err;

    logic [7:0]  vdo [6];
    logic [7:0]  ldo [6];
    logic [5:0]  ack;
    logic [5:0]  err;

    int checks   = 0;
    int failures = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_lat
        vram_multibank #(.NBANK(2), .AW(11), .DW(8), .RD_LAT(g + 1), .OPEN_BUS_HOLD(1)) u_dut (
            .CLK(clk), .RESB(rst_n), .CE(ce), .VA(va), .VDI(vdi), .nVCS(nvcs), .nVWE(nvwe),
            .VDO(vdo[g]), .LD_REQ(ld_req), .LD_WE(ld_we), .LD_BANK(ld_bank[0:0]), .LD_A(ld_a),
            .LD_DI(ld_di), .LD_ACK(ack[g]), .LD_DO(ldo[g]), .CLR_ERR(clr_err), .MULTI_CS_ERR(err[g])
        );
    end

    vram_multibank #(.NBANK(2), .AW(11), .DW(8), .RD_LAT(2), .OPEN_BUS_HOLD(0)) u_nohold (
        .CLK(clk), .RESB(rst_n), .CE(ce), .VA(va), .VDI(vdi), .nVCS(nvcs), .nVWE(nvwe),
        .VDO(vdo[4]), .LD_REQ(ld_req), .LD_WE(ld_we), .LD_BANK(ld_bank[0:0]), .LD_A(ld_a),
        .LD_DI(ld_di), .LD_ACK(ack[4]), .LD_DO(ldo[4]), .CLR_ERR(clr_err), .MULTI_CS_ERR(err[4])
    );

    vram_multibank #(.NBANK(3), .AW(11), .DW(8), .RD_LAT(2), .OPEN_BUS_HOLD(1)) u_three (
        .CLK(clk), .RESB(rst_n), .CE(ce), .VA(va), .VDI(vdi), .nVCS({1'b1, nvcs}), .nVWE(nvwe),
        .VDO(vdo[5]), .LD_REQ(ld_req), .LD_WE(ld_we), .LD_BANK(ld_bank), .LD_A(ld_a),
        .LD_DI(ld_di), .LD_ACK(ack[5]), .LD_DO(ldo[5]), .CLR_ERR(clr_err), .MULTI_CS_ERR(err[5])
    );

    // Model: plain memory arrays plus a history of launched slots, newest first
    typedef struct packed {
        logic       v;
        logic [7:0] d;
    } slot_t;

    int         lat  [6] = '{1, 2, 3, 4, 2, 2};
    int         hold [6] = '{1, 1, 1, 1, 0, 1};
    int         nb   [6] = '{2, 2, 2, 2, 2, 3};
    logic [7:0] mm [0:1][0:2047];
    slot_t      hist [4];
    logic [7:0] e_vdo [6];
    logic [7:0] e_ldo [6];
    logic       e_ack;
    logic       e_rd;
    logic       e_err;
    int         m_nsel;
    int         m_bank;
    int         m_eff;
    logic       m_vdc;
    slot_t      m_slot;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist[i] = '0;
            for (int k = 0; k < 6; k++) begin
                e_vdo[k] = 8'hFF;
                e_ldo[k] = 8'h00;
            end
            e_ack = 1'b0;
            e_rd  = 1'b0;
            e_err = 1'b0;
        end else begin
            m_nsel = 0;
            if (!nvcs[0]) m_nsel++;
            if (!nvcs[1]) m_nsel++;
            m_vdc  = ce && (m_nsel > 0);
            m_slot = '0;
            if (m_vdc && m_nsel > 1) begin
                m_slot = {1'b1, 8'hFF};
                e_err  = 1'b1;
            end else begin
                if (clr_err) e_err = 1'b0;
                if (m_vdc) begin
                    m_bank = nvcs[0] ? 1 : 0;
                    if (nvwe) m_slot = {1'b1, mm[m_bank][va]};
                    else mm[m_bank][va] = vdi;
                end
            end
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = m_slot;
            for (int k = 0; k < 6; k++) begin
                if (hist[lat[k]-1].v) e_vdo[k] = hist[lat[k]-1].d;
                else if (hold[k] == 0) e_vdo[k] = 8'hFF;
            end
            if (!e_ack && ld_req && !m_vdc) begin
                e_ack = 1'b1;
                e_rd  = !ld_we;
                if (ld_we) begin
                    mm[ld_bank[0]][ld_a] = ld_di;
                end else begin
                    for (int k = 0; k < 6; k++) begin
                        m_eff    = (nb[k] == 2) ? int'(ld_bank[0]) : int'(ld_bank);
                        e_ldo[k] = (m_eff < nb[k]) ? mm[m_eff][ld_a] : 8'hFF;
                    end
                end
            end else begin
                e_ack = 1'b0;
            end
        end
    end

    task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
        if ($isunknown(exp)) return;
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int k = 0; k < 6; k++) begin
                check_output($sformatf("vdo[%0d]", k), vdo[k], e_vdo[k]);
                check_output($sformatf("ld_ack[%0d]", k), {7'b0, ack[k]}, {7'b0, e_ack});
                check_output($sformatf("err[%0d]", k), {7'b0, err[k]}, {7'b0, e_err});
                if (e_ack && e_rd)
                    check_output($sformatf("ld_do[%0d]", k), ldo[k], e_ldo[k]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce      = 1'b0;
        nvcs    = 2'b11;
        nvwe    = 1'b1;
        clr_err = 1'b0;
    endtask

    task automatic vdc_access(input int bank, input logic wr, input logic [10:0] a, input logic [7:0] d);
        ce   = 1'b1;
        nvcs = (bank == 0) ? 2'b10 : 2'b01;
        nvwe = !wr;
        va   = a;
        vdi  = d;
        tick(1);
        idle();
    endtask

    task automatic multi_select(input logic wr);
        ce   = 1'b1;
        nvcs = 2'b00;
        nvwe = !wr;
        va   = 11'h010;
        vdi  = 8'h55;
        tick(1);
        idle();
    endtask

    task automatic ld_op(input logic we, input logic [1:0] bank, input logic [10:0] a, input logic [7:0] d);
        bit got = 0;
        ld_we   = we;
        ld_bank = bank;
        ld_a    = a;
        ld_di   = d;
        ld_req  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (ack[1]) begin
                got = 1;
                break;
            end
        end
        ld_req = 1'b0;
        check_output("ld_ack_wait", {7'b0, got}, 8'd1);
    endtask

    task automatic apply_stimulus();
        logic [10:0] rd_addr [5] = '{11'h010, 11'h7FF, 11'h020, 11'h020, 11'h7FF};
        int          rd_bank [5] = '{0, 1, 0, 1, 0};

        // Preload and readback
        ld_op(1'b1, 2'd0, 11'h010, 8'h3C);
        ld_op(1'b1, 2'd0, 11'h7FF, 8'h11);
        ld_op(1'b1, 2'd1, 11'h7FF, 8'hA5);
        ld_op(1'b1, 2'd1, 11'h010, 8'h77);
        ld_op(1'b1, 2'd0, 11'h020, 8'hC3);
        ld_op(1'b1, 2'd1, 11'h020, 8'h99);
        ld_op(1'b0, 2'd1, 11'h7FF, 8'h00);
        check_output("ld_read_a5", ldo[1], 8'hA5);
        tick(1);
        check_output("ld_ack_single", {7'b0, ack[1]}, 8'd0);
        ld_op(1'b0, 2'd0, 11'h7FF, 8'h00);
        check_output("bank0_untouched", ldo[1], 8'h11);

        // Read latency across RD_LAT 1..4
        vdc_access(1, 1'b0, 11'h010, 8'h00);
        tick(4);
        vdc_access(0, 1'b0, 11'h010, 8'h00);
        check_output("lat1_at_e", vdo[0], 8'h3C);
        check_output("lat2_at_e", vdo[1], 8'h77);
        tick(1);
        check_output("lat2_at_e1", vdo[1], 8'h3C);
        check_output("lat3_at_e1", vdo[2], 8'h77);
        tick(1);
        check_output("lat3_at_e2", vdo[2], 8'h3C);
        check_output("nohold_idle", vdo[4], 8'hFF);
        tick(1);
        check_output("lat4_at_e3", vdo[3], 8'h3C);

        // Read-after-write coherence from both ports
        vdc_access(1, 1'b1, 11'h030, 8'h5A);
        vdc_access(1, 1'b0, 11'h030, 8'h00);
        tick(1);
        check_output("vdc_raw", vdo[1], 8'h5A);
        ld_op(1'b1, 2'd0, 11'h040, 8'hE7);
        vdc_access(0, 1'b0, 11'h040, 8'h00);
        check_output("ld_then_vdc_raw", vdo[0], 8'hE7);
        tick(2);

        // Arbitration: loader waits out a burst of VDC reads
        ld_we   = 1'b0;
        ld_bank = 2'd0;
        ld_a    = 11'h010;
        ld_req  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ce   = 1'b1;
            nvwe = 1'b1;
            nvcs = (rd_bank[i] == 0) ? 2'b10 : 2'b01;
            va   = rd_addr[i];
            tick(1);
        end
        idle();
        check_output("arb_no_ack", {7'b0, ack[1]}, 8'd0);
        tick(1);
        check_output("arb_ack", {7'b0, ack[1]}, 8'd1);
        check_output("arb_ld_do", ldo[1], 8'h3C);
        ld_req = 1'b0;
        tick(3);

        // Multi-select: no write, open-bus read, sticky flag, set beats clear
        multi_select(1'b1);
        check_output("multi_err_set", {7'b0, err[1]}, 8'd1);
        ld_op(1'b0, 2'd0, 11'h010, 8'h00);
        check_output("multi_no_wr_b0", ldo[1], 8'h3C);
        tick(1);
        ld_op(1'b0, 2'd1, 11'h010, 8'h00);
        check_output("multi_no_wr_b1", ldo[1], 8'h77);
        multi_select(1'b0);
        tick(1);
        check_output("multi_read_ff", vdo[1], 8'hFF);
        tick(3);
        check_output("multi_err_sticky", {7'b0, err[1]}, 8'd1);
        clr_err = 1'b1;
        multi_select(1'b0);
        check_output("multi_set_wins", {7'b0, err[1]}, 8'd1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check_output("multi_cleared", {7'b0, err[1]}, 8'd0);

        // Open bus through idle cycles and writes
        vdc_access(0, 1'b0, 11'h010, 8'h00);
        tick(2);
        vdc_access(0, 1'b1, 11'h050, 8'h12);
        tick(1);
        vdc_access(1, 1'b1, 11'h050, 8'h34);
        tick(3);
        check_output("hold_lat2", vdo[1], 8'h3C);
        check_output("hold_lat4", vdo[3], 8'h3C);
        check_output("nohold_ff", vdo[4], 8'hFF);

        // Loader bank index beyond the array
        ld_op(1'b0, 2'd3, 11'h7FF, 8'h00);
        check_output("bad_bank_ff", ldo[5], 8'hFF);
        check_output("bank3_alias_2b", ldo[1], 8'hA5);
        tick(2);

        // Reset in the middle of a read
        multi_select(1'b0);
        vdc_access(0, 1'b0, 11'h010, 8'h00);
        tick(4);
        vdc_access(1, 1'b0, 11'h010, 8'h00);
        rst_n = 1'b0;
        #1;
        check_output("rst_vdo", vdo[1], 8'hFF);
        check_output("rst_vdo4", vdo[3], 8'hFF);
        check_output("rst_ack", {7'b0, ack[1]}, 8'd0);
        check_output("rst_err", {7'b0, err[1]}, 8'd0);
        check_output("rst_ld_do", ldo[1], 8'h00);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(4);
        check_output("rst_no_stale", vdo[3], 8'hFF);

        // Loader write granted just before reset survives it
        ld_op(1'b1, 2'd0, 11'h060, 8'h6B);
        rst_n = 1'b0;
        #1;
        check_output("rst_drop_ack", {7'b0, ack[1]}, 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(1);
        ld_op(1'b0, 2'd0, 11'h060, 8'h00);
        check_output("rst_keep_write", ldo[1], 8'h6B);
        tick(2);
    endtask

    initial begin
        rst_n   = 1'b1;
        ld_req  = 1'b0;
        ld_we   = 1'b0;
        ld_bank = 2'd0;
        ld_a    = '0;
        ld_di   = '0;
        va      = '0;
        vdi     = '0;
        idle();
        #1 rst_n = 1'b0;
        #1;
        check_output("init_vdo", vdo[1], 8'hFF);
        check_output("init_ack", {7'b0, ack[1]}, 8'd0);
        check_output("init_err", {7'b0, err[1]}, 8'd0);
        check_output("init_ld_do", ldo[1], 8'h00);
        tick(2);
        rst_n    = 1'b1;
        checking = 1;
        tick(1);
        apply_stimulus();
        checking = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
